// File: rtl/if_fetch_pkg.sv
// Shared constants, state encoding and byte-assembly helper for the instruction-fetch stage.
package if_fetch_pkg;

    localparam logic        ENABLE      = 1'b1;
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StValid = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    // Little-endian: byte idx lands in bits [8*idx +: 8].
    function automatic logic [INST_W-1:0] put_byte(input logic [INST_W-1:0] word,
                                                   input logic [1:0]        idx,
                                                   input logic [7:0]        data);
        logic [INST_W-1:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup port and single-word fill port.
// Valid bits clear on rst; tag and data storage are not reset.
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int unsigned LINES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] lookup_addr,
    output logic                   lookup_hit,
    output logic [INST_W-1:0]      lookup_inst,
    input  logic                   fill_en,
    input  logic [INST_ADDR_W-1:0] fill_addr,
    input  logic [INST_W-1:0]      fill_inst
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = INST_ADDR_W - IDX_W - 2;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign lookup_idx = lookup_addr[IDX_W+1:2];
    assign lookup_tag = lookup_addr[INST_ADDR_W-1:IDX_W+2];
    assign fill_idx   = fill_addr[IDX_W+1:2];
    assign fill_tag   = fill_addr[INST_ADDR_W-1:IDX_W+2];

    assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign lookup_inst = data_q[lookup_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst == ENABLE) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_inst;
        end
    end

    // Word-aligned addresses: the byte offset carries no information here.
    logic unused_offset;
    assign unused_offset = ^{lookup_addr[1:0], fill_addr[1:0]};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit words from byte reads and hands them to decode.
// Optional direct-mapped i-cache enabled by defining IF_ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC     = 32'h0,
    parameter int unsigned            ICACHE_LINES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   jump_i,
    input  logic [INST_ADDR_W-1:0] jump_addr_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [7:0]             mem_data_i,
    output logic                   first_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [INST_W-1:0]      inst_q, inst_d;
    logic                   first_d;
    logic [INST_ADDR_W-1:0] pc_o_d;
    logic [INST_W-1:0]      inst_o_d;
    logic                   req_d;
    logic [INST_ADDR_W-1:0] addr_d;
    logic                   hit_q, hit_d;
    logic [INST_W-1:0]      hit_inst_q;
    logic                   fill_en;
    logic                   keep_req;
    logic                   lookup_en;
    logic                   cache_hit;
    logic [INST_W-1:0]      cache_inst;

`ifdef IF_ICACHE_EN
    if_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (pc_d),
        .lookup_hit  (cache_hit),
        .lookup_inst (cache_inst),
        .fill_en     (fill_en),
        .fill_addr   (pc_q),
        .fill_inst   (inst_o_d)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_inst = ZERO_WORD;

    logic unused_cfg;
    assign unused_cfg = fill_en ^ ICACHE_LINES[0];
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        inst_d   = inst_q;
        first_d  = first_o;
        pc_o_d   = pc_o;
        inst_o_d = inst_o;
        fill_en  = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (jump_i) begin
                    pc_d    = jump_addr_i;
                    cnt_d   = 2'd0;
                    first_d = 1'b0;
                    // An unanswered request must be drained before refetching.
                    state_d = (mem_req_o && !mem_ack_i) ? StDrain : StFetch;
                end else if (hit_q) begin
                    state_d  = StValid;
                    first_d  = 1'b1;
                    pc_o_d   = pc_q;
                    inst_o_d = hit_inst_q;
                end else if (mem_req_o && mem_ack_i) begin
                    inst_d = put_byte(inst_q, cnt_q, mem_data_i);
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d  = StValid;
                        first_d  = 1'b1;
                        pc_o_d   = pc_q;
                        inst_o_d = inst_d;
                        fill_en  = 1'b1;
                    end
                end
            end
            StValid: begin
                if (jump_i) begin
                    pc_d    = jump_addr_i;
                    cnt_d   = 2'd0;
                    first_d = 1'b0;
                    state_d = StFetch;
                end else if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = 2'd0;
                    first_d = 1'b0;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                cnt_d = 2'd0;
                if (jump_i) begin
                    pc_d    = jump_addr_i;
                    first_d = 1'b0;
                end
                if (mem_ack_i) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Request and address are registered so they only move on clock edges.
    always_comb begin
        keep_req  = (state_q == StFetch) && mem_req_o && !mem_ack_i && !jump_i;
        lookup_en = (state_d == StFetch) && (cnt_d == 2'd0) && !keep_req;
        hit_d     = lookup_en && cache_hit;
        req_d     = 1'b0;
        addr_d    = mem_addr_o;

        unique case (state_d)
            StFetch: begin
                req_d  = !hit_d;
                addr_d = pc_d + {30'd0, cnt_d};
            end
            StDrain: begin
                req_d = 1'b1;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == ENABLE) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            inst_q     <= ZERO_WORD;
            first_o    <= 1'b0;
            pc_o       <= ZERO_WORD;
            inst_o     <= ZERO_WORD;
            mem_req_o  <= 1'b0;
            mem_addr_o <= ZERO_WORD;
            hit_q      <= 1'b0;
            hit_inst_q <= ZERO_WORD;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            inst_q     <= inst_d;
            first_o    <= first_d;
            pc_o       <= pc_o_d;
            inst_o     <= inst_o_d;
            mem_req_o  <= req_d;
            mem_addr_o <= addr_d;
            hit_q      <= hit_d;
            hit_inst_q <= cache_inst;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-memory model with zero-wait acks, vector table plus
// hand-written redirect, drain, wrap, reset and (with IF_ICACHE_EN) cache-hit sequences.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_data_i = 8'h00;
    logic        first_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [1024];
    logic        hold_ack = 1'b0;
    int          req_cycles = 0;
    logic [31:0] ack_log [$];

    typedef struct {
        int          stall;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs [4];

    if_fetch #(
        .RESET_PC     (32'h0),
        .ICACHE_LINES (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .first_o     (first_o),
        .pc_o        (pc_o),
        .inst_o      (inst_o)
    );

    always #5 clk = ~clk;

    // Memory answers a held request in the same cycle unless hold_ack is set.
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (mem_req_o === 1'b1) begin
            req_cycles++;
            if (!hold_ack) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem[mem_addr_o[9:0]];
                ack_log.push_back(mem_addr_o);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_first(output int n);
        n = 0;
        while (first_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("first_seen", {31'd0, first_o}, 32'd1);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n;
        n = 0;
        while (mem_addr_o !== a && n < 50) begin
            tick();
            n++;
        end
        check("addr_reached", mem_addr_o, a);
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]     = w[7:0];
        mem[a + 1] = w[15:8];
        mem[a + 2] = w[23:16];
        mem[a + 3] = w[31:24];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        rst         = 1'b1;
        stall_i     = 1'b0;
        jump_i      = 1'b0;
        jump_addr_i = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        put_word(32'h000, 32'h00500513);
        put_word(32'h004, 32'h00A00593);
        put_word(32'h008, 32'h00B50633);
        put_word(32'h00C, 32'h0000006F);
        put_word(32'h100, 32'h12345678);
        put_word(32'h200, 32'hCAFEF00D);
        put_word(32'h3FC, 32'h0BADC0DE);

        vecs[0] = '{3, 32'h000, 32'h00500513};
        vecs[1] = '{0, 32'h004, 32'h00A00593};
        vecs[2] = '{1, 32'h008, 32'h00B50633};
        vecs[3] = '{0, 32'h00C, 32'h0000006F};

        // Reset state
        tick();
        tick();
        check("rst_first", {31'd0, first_o}, 32'd0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);

        rst = 1'b0;
        tick();
        check("first_req", {31'd0, mem_req_o}, 32'd1);
        check("first_addr", mem_addr_o, 32'h0);
        wait_first(n);
        check("first_lat", n, 32'd4);
        check("log_size", ack_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) check("addr_order", ack_log[i], i);

        // Table: deliver, optionally stall, then handshake
        for (int v = 0; v < 4; v++) begin
            if (v > 0) begin
                wait_first(n);
                check("vec_lat", n, 32'd4);
            end
            check("vec_pc", pc_o, vecs[v].pc);
            check("vec_inst", inst_o, vecs[v].inst);
            if (vecs[v].stall > 0) begin
                stall_i = 1'b1;
                for (int k = 0; k < vecs[v].stall; k++) begin
                    tick();
                    check("stall_first", {31'd0, first_o}, 32'd1);
                    check("stall_pc", pc_o, vecs[v].pc);
                    check("stall_inst", inst_o, vecs[v].inst);
                    check("stall_req", {31'd0, mem_req_o}, 32'd0);
                end
                stall_i = 1'b0;
            end
            tick();
            check("hs_first", {31'd0, first_o}, 32'd0);
            check("hs_req", {31'd0, mem_req_o}, 32'd1);
            check("hs_addr", mem_addr_o, vecs[v].pc + 32'd4);
        end

        // Redirect while the byte-2 ack is outstanding -> drain
        wait_addr(32'h12);
        hold_ack = 1'b1;
        tick();
        tick();
        check("hold_req", {31'd0, mem_req_o}, 32'd1);
        check("hold_addr", mem_addr_o, 32'h12);
        jump_i      = 1'b1;
        jump_addr_i = 32'h100;
        tick();
        jump_i = 1'b0;
        check("drain_first", {31'd0, first_o}, 32'd0);
        check("drain_req", {31'd0, mem_req_o}, 32'd1);
        check("drain_addr", mem_addr_o, 32'h12);
        hold_ack = 1'b0;
        tick();
        check("post_drain_addr", mem_addr_o, 32'h100);
        wait_first(n);
        check("jmp_lat", n, 32'd4);
        check("jmp_pc", pc_o, 32'h100);
        check("jmp_inst", inst_o, 32'h12345678);

        // Redirect in the handshake cycle beats the handshake
        jump_i      = 1'b1;
        jump_addr_i = 32'h200;
        tick();
        jump_i = 1'b0;
        check("jhs_first", {31'd0, first_o}, 32'd0);
        check("jhs_addr", mem_addr_o, 32'h200);
        wait_first(n);
        check("jhs_pc", pc_o, 32'h200);
        check("jhs_inst", inst_o, 32'hCAFEF00D);

        // pc wraps from the top of the address space
        jump_i      = 1'b1;
        jump_addr_i = 32'hFFFF_FFFC;
        tick();
        jump_i = 1'b0;
        wait_first(n);
        check("top_pc", pc_o, 32'hFFFF_FFFC);
        check("top_inst", inst_o, 32'h0BADC0DE);
        tick();
`ifndef IF_ICACHE_EN
        check("wrap_addr", mem_addr_o, 32'h0);
`endif
        wait_first(n);
        check("wrap_pc", pc_o, 32'h0);
        check("wrap_inst", inst_o, 32'h00500513);

        // Reset in the middle of a fetch (byte_cnt = 2)
        jump_i      = 1'b1;
        jump_addr_i = 32'h300;
        tick();
        jump_i = 1'b0;
        wait_addr(32'h302);
        rst = 1'b1;
        #1;
        check("mrst_first", {31'd0, first_o}, 32'd0);
        check("mrst_pc", pc_o, 32'h0);
        check("mrst_inst", inst_o, 32'h0);
        check("mrst_req", {31'd0, mem_req_o}, 32'd0);
        check("mrst_addr", mem_addr_o, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("refetch_req", {31'd0, mem_req_o}, 32'd1);
        check("refetch_addr", mem_addr_o, 32'h0);
        wait_first(n);
        check("refetch_pc", pc_o, 32'h0);
        check("refetch_inst", inst_o, 32'h00500513);

`ifdef IF_ICACHE_EN
        // Loop back to 0: second pass must come from the cache
        tick();
        wait_first(n);
        check("loop1_pc4", pc_o, 32'h4);
        tick();
        wait_first(n);
        check("loop1_pc8", pc_o, 32'h8);
        jump_i      = 1'b1;
        jump_addr_i = 32'h0;
        tick();
        jump_i = 1'b0;
        snap   = req_cycles;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            wait_first(n);
            check("hit_lat", n, 32'd1);
            check("hit_pc", pc_o, 32'(4 * i));
            check("hit_inst", inst_o, vecs[i].inst);
        end
        check("hit_no_req", req_cycles - snap, 32'd0);
`else
        snap = req_cycles;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
